// File: rtl/rf_wport_arbiter.sv
// Purpose: shares the register-file write port between writeback (W) and a queued long-latency unit (LU).
// Latency: a grant in cycle t drives rf_we/rf_waddr/rf_wdata at t+1; an LU push is poppable at t+1 at the earliest.
// Backpressure: lu_ready drops while the LU FIFO is full; wb_ready drops only when a starved LU result is forced ahead of W.
module rf_wport_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_en,
    input  logic        wb_valid,
    input  logic        wb_we,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        lu_valid,
    input  logic [4:0]  lu_dest,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending_mask
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(STARVE_MAX);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // FIFO storage and bookkeeping
    logic [4:0]        dest_q [DEPTH];
    logic [4:0]        dest_d [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [31:0]       data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Registered write-port outputs and hazard mask
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;
    logic [31:0]       pending_mask_q, pending_mask_d;

    // Per-cycle decisions
    logic              empty;
    logic              full;
    logic              force_lu;
    logic              pop;
    logic              push;
    logic              w_grant;
    logic              wb_ready_c;
    logic [4:0]        head_dest;
    logic [31:0]       head_data;
    logic [PTR_W-1:0]  slot_offs;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_FULL);
    assign force_lu  = (wait_cnt_q == WAIT_SAT) && !empty;
    assign head_dest = dest_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    assign lu_ready  = rstn & ~full;
    assign push      = lu_valid & lu_ready & ~ex_en;
    assign wb_ready  = rstn & wb_ready_c;

    // Port grant: starved LU first, then a W GPR write, then any queued LU result
    always_comb begin
        pop        = 1'b0;
        w_grant    = 1'b0;
        wb_ready_c = 1'b1;
        if (force_lu) begin
            pop        = 1'b1;
            wb_ready_c = 1'b0;
        end else if (wb_valid && wb_we) begin
            w_grant = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
        // A flush cancels whatever would have been granted this cycle
        if (ex_en) begin
            pop     = 1'b0;
            w_grant = 1'b0;
        end
    end

    // Next-state for FIFO, starvation counter and registered write port
    always_comb begin
        dest_d     = dest_q;
        data_d     = data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        wait_cnt_d = wait_cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (ex_en) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            wait_cnt_d = '0;
        end else begin
            if (push) begin
                dest_d[wr_ptr_q] = lu_dest;
                data_d[wr_ptr_q] = lu_data;
                wr_ptr_d         = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase

            // Counts how long a queued LU result has been passed over
            if (pop || empty) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != WAIT_SAT) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end

            // r0 writes still use up the slot but never reach the regfile
            if (pop) begin
                rf_we_d = (head_dest != 5'd0);
                if (head_dest != 5'd0) begin
                    rf_waddr_d = head_dest;
                    rf_wdata_d = head_data;
                end
            end else if (w_grant) begin
                rf_we_d = (wb_dest != 5'd0);
                if (wb_dest != 5'd0) begin
                    rf_waddr_d = wb_dest;
                    rf_wdata_d = wb_data;
                end
            end
        end
    end

    // Pending mask reflects the FIFO contents as they will be after this cycle
    always_comb begin
        pending_mask_d = '0;
        slot_offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_offs = PTR_W'(i) - rd_ptr_d;
            if (CNT_W'(slot_offs) < cnt_d) begin
                pending_mask_d[dest_d[i]] = 1'b1;
            end
        end
        pending_mask_d[0] = 1'b0;
    end

    // Control and output state, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            wait_cnt_q     <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            pending_mask_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            pending_mask_q <= pending_mask_d;
        end
    end

    // FIFO payload storage; validity is tracked by the occupancy count alone
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign pending_mask = pending_mask_q;

endmodule
